// File: rtl/neuron_seq_pkg.sv
// Shared types and defaults for the neuron MAC sequencer.
package neuron_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned NEURON_N     = 18;
   localparam int unsigned NEURON_DEPTH = 16;

   // Width of the accumulator that ReLU slices its activation from.
   localparam int unsigned RELU_ACC_W = 2 * NEURON_N;

endpackage

// File: rtl/neuron_seq_mac.sv
// Signed NxN multiplier feeding a 2N-bit wrapping accumulator with synchronous clear.
module mac_clr_Nbits #(
   parameter int unsigned N = 18
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  en,
   input  logic signed [N-1:0]   a,
   input  logic signed [N-1:0]   b,
   output logic signed [2*N-1:0] acc
);

   localparam int unsigned ACC_W = 2 * N;

   logic signed [ACC_W-1:0] prod;

   // Operands are sign-extended first so the low 2N bits hold the exact product.
   always_comb begin
      prod = ACC_W'(a) * ACC_W'(b);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + prod;
      end
   end

endmodule

// File: rtl/neuron_seq.sv
// Sequences one neuron's MAC pass over external W/X memory and presents the ReLU result.
module neuron_seq
   import neuron_seq_pkg::*;
#(
   parameter int unsigned N     = NEURON_N,
   parameter int unsigned DEPTH = NEURON_DEPTH,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [AW:0]         len,
   output logic                busy,
   output logic                mem_rd,
   output logic [AW-1:0]       mem_addr,
   input  logic signed [N-1:0] w_data,
   input  logic signed [N-1:0] x_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N-1:0]        out_data
);

   localparam int unsigned KW    = AW + 1;
   localparam int unsigned ACC_W = 2 * N;

   state_t                  state;
   logic [KW-1:0]           k_q;
   logic                    rd_dly;
   logic signed [ACC_W-1:0] acc;
   logic [KW-1:0]           k_c;
   logic                    clr_c;
   logic                    last_c;
   logic                    unused_acc_lsb;

   always_comb begin
      k_c    = (len > KW'(DEPTH)) ? KW'(DEPTH) : len;
      clr_c  = (state == IDLE) && start;
      last_c = (KW'(mem_addr) == (k_q - KW'(1)));
   end

   // Control FSM; address counter and read-valid delay register share the block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         k_q       <= '0;
         rd_dly    <= 1'b0;
         busy      <= 1'b0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         out_valid <= 1'b0;
      end else begin
         rd_dly <= mem_rd;
         case (state)
            IDLE: begin
               if (start) begin
                  k_q      <= k_c;
                  mem_addr <= '0;
                  busy     <= 1'b1;
                  if (k_c == '0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                  end else begin
                     state  <= FETCH;
                     mem_rd <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (last_c) begin
                  state    <= DRAIN;
                  mem_rd   <= 1'b0;
                  mem_addr <= '0;
               end else begin
                  mem_addr <= mem_addr + AW'(1);
               end
            end
            DRAIN: begin
               state     <= DONE;
               out_valid <= 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   mac_clr_Nbits #(
      .N (N)
   ) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (clr_c),
      .en  (rd_dly),
      .a   (w_data),
      .b   (x_data),
      .acc (acc)
   );

   // ReLU on the frozen accumulator; the low half is fractional and dropped.
   always_comb begin
      out_data = acc[ACC_W-1] ? '0 : acc[ACC_W-1:N];
   end

   assign unused_acc_lsb = ^acc[N-1:0];

endmodule

// File: tb/tb_neuron_seq.sv
// Directed vector bench for neuron_seq with a synchronous-read W/X memory model.
module tb_neuron_seq;

   localparam int unsigned N     = 18;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;

   logic                clk;
   logic                rst;
   logic                start;
   logic [AW:0]         len;
   logic                busy;
   logic                mem_rd;
   logic [AW-1:0]       mem_addr;
   logic signed [N-1:0] w_data;
   logic signed [N-1:0] x_data;
   logic                out_valid;
   logic                out_ready;
   logic [N-1:0]        out_data;

   logic signed [N-1:0] w_mem [DEPTH];
   logic signed [N-1:0] x_mem [DEPTH];

   int checks   = 0;
   int errors   = 0;
   int rd_cnt   = 0;
   int addr_err = 0;
   int run_idx  = 0;
   logic prev_rd = 1'b0;

   typedef struct {
      logic [4:0] len;
      int         w0;
      int         x0;
      int         wr;
      int         xr;
      int         exp_out;
      int         exp_lat;
      int         exp_reads;
   } vec_t;

   vec_t vecs [9];

   neuron_seq #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .w_data    (w_data),
      .x_data    (x_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd) begin
         w_data <= w_mem[mem_addr];
         x_data <= x_mem[mem_addr];
      end
   end

   // Each burst of reads must walk addresses 0,1,2,... from its first strobe.
   always @(negedge clk) begin
      if (mem_rd) begin
         if (!prev_rd) run_idx = 0;
         if (int'(mem_addr) != run_idx) addr_err++;
         run_idx++;
         rd_cnt++;
      end
      prev_rd = mem_rd;
   end

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic load_mem(input vec_t v);
      for (int i = 0; i < int'(DEPTH); i++) begin
         w_mem[i] = (i == 0) ? N'(v.w0) : N'(v.wr);
         x_mem[i] = (i == 0) ? N'(v.x0) : N'(v.xr);
      end
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_pass(input vec_t v, input int idx);
      int lat;
      int r0;
      int a0;
      load_mem(v);
      r0 = rd_cnt;
      a0 = addr_err;
      @(negedge clk);
      start = 1'b1;
      len   = v.len;
      @(negedge clk);
      start = 1'b0;
      wait_valid(lat);
      chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
      chk($sformatf("v%0d out_data", idx), out_data, v.exp_out);
      chk($sformatf("v%0d reads", idx), rd_cnt - r0, v.exp_reads);
      chk($sformatf("v%0d addr_seq_errs", idx), addr_err - a0, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("v%0d busy_after_hs", idx), busy, 0);
   endtask

   initial begin
      int   lat;
      int   r0;
      vec_t bp;

      vecs[0] = '{5'd1,   512,   512,   512,  512,     1,  3,  1};
      vecs[1] = '{5'd4,   512,   512,   512,  512,     4,  6,  4};
      vecs[2] = '{5'd2,  1024,   512,  -768, 1024,     0,  4,  2};
      vecs[3] = '{5'd1,  -512,  -512,  -512, -512,     1,  3,  1};
      vecs[4] = '{5'd0,     0,     0,     0,    0,     0,  1,  0};
      vecs[5] = '{5'd31,  512,   512,   512,  512,    16, 18, 16};
      vecs[6] = '{5'd3, 131071, 131071, 131071, 131071, 0, 5,  3};
      vecs[7] = '{5'd1, -131072, -131072, -131072, -131072, 65536, 3, 1};
      vecs[8] = '{5'd3,  2048,   512,  -512,  512,     2,  5,  3};

      rst       = 1'b1;
      start     = 1'b0;
      len       = '0;
      out_ready = 1'b0;
      w_data    = '0;
      x_data    = '0;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset mem_rd", mem_rd, 0);
      chk("reset mem_addr", mem_addr, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_data", out_data, 0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_pass(vecs[i], i);

      // Backpressure: result must hold while start/len toggle in DONE.
      bp = '{5'd2, 512, 512, 512, 512, 2, 4, 2};
      load_mem(bp);
      @(negedge clk);
      start = 1'b1;
      len   = 5'd2;
      @(negedge clk);
      start = 1'b0;
      wait_valid(lat);
      chk("bp latency", lat, 4);
      r0 = rd_cnt;
      for (int i = 0; i < 5; i++) begin
         start = ~start;
         len   = 5'(i + 3);
         @(negedge clk);
         chk($sformatf("bp%0d out_valid", i), out_valid, 1);
         chk($sformatf("bp%0d out_data", i), out_data, 2);
      end
      chk("bp no_reads", rd_cnt - r0, 0);
      out_ready = 1'b1;
      start     = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      start     = 1'b0;
      chk("bp busy_after_hs", busy, 0);
      chk("bp out_valid_after_hs", out_valid, 0);
      @(negedge clk);
      chk("bp start_ignored_busy", busy, 0);
      chk("bp start_ignored_rd", rd_cnt - r0, 0);

      // Reset in cycle 3 of an 8-term pass.
      load_mem(vecs[1]);
      @(negedge clk);
      start = 1'b1;
      len   = 5'd8;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid busy_before_rst", busy, 1);
      chk("mid out_data_before_rst", out_data, 1);
      rst = 1'b0;
      #1;
      chk("mid rst busy", busy, 0);
      chk("mid rst mem_rd", mem_rd, 0);
      chk("mid rst mem_addr", mem_addr, 0);
      chk("mid rst out_valid", out_valid, 0);
      chk("mid rst out_data", out_data, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_pass(vecs[0], 100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
